// File: rtl/core_mem_model.sv
// core_mem_model: word-addressed simulation memory for riscv_core benches.
// It has a combinational fetch port and a pipelined data port, and it can be
// preloaded while the core is held in reset. A store to the mailbox address
// halts the model and captures a result code, and a cycle counter is provided.
module core_mem_model #(
   parameter int          DEPTH      = 1024,
   parameter int          RD_LATENCY = 1,
   parameter logic [31:0] HALT_ADDR  = 32'h0000_1000,
   parameter logic [31:0] INIT_WORD  = 32'h0000_0013,
   localparam int         AW         = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [31:0]   instr_addr,
   output logic [31:0]   instr_data,
   input  logic [31:0]   data_addr,
   input  logic [31:0]   data_wdata,
   input  logic          data_we,
   input  logic          data_re,
   output logic [31:0]   data_rdata,
   output logic          data_rvalid,
   input  logic          load_en,
   input  logic [AW-1:0] load_addr,
   input  logic [31:0]   load_data,
   output logic          halted,
   output logic [31:0]   halt_code,
   output logic [31:0]   cycle_count,
   output logic          err
);

   if (DEPTH < 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("core_mem_model: DEPTH must be a power of two and at least 16");
   end
   if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
      $error("core_mem_model: RD_LATENCY must be in 1..4");
   end

   // Storage starts out filled with NOPs. Reset never touches it, so a
   // program that is preloaded during reset survives reset release.
   logic [31:0] mem_q [DEPTH] = '{default: INIT_WORD};

   logic          vld_q  [RD_LATENCY];
   logic [31:0]   rdat_q [RD_LATENCY];

   logic          halted_q, halted_d;
   logic [31:0]   halt_code_q, halt_code_d;
   logic [31:0]   cycle_q, cycle_d;
   logic          err_q, err_d;

   logic [AW-1:0] fetch_idx;
   logic          fetch_in_range;
   logic [AW-1:0] data_idx;
   logic          data_ok;
   logic          data_is_halt;
   logic          access_err;
   logic          store_en;
   logic [31:0]   load_word;
   logic          unused_fetch_lsbs;

   // Fetch: word index from the byte address. Out-of-range fetches read as a NOP.
   assign fetch_idx         = instr_addr[AW+1:2];
   assign fetch_in_range    = ~|instr_addr[31:AW+2];
   assign instr_data        = fetch_in_range ? mem_q[fetch_idx] : INIT_WORD;
   assign unused_fetch_lsbs = ^instr_addr[1:0];

   // The mailbox lies outside the array. Touching it is therefore not an
   // access error, but it never reaches storage.
   assign data_idx     = data_addr[AW+1:2];
   assign data_ok      = ~|data_addr[31:AW+2] && (data_addr[1:0] == 2'b00);
   assign data_is_halt = (data_addr == HALT_ADDR);
   assign access_err   = (data_we || data_re) && !data_ok && !data_is_halt;
   // A preload to the same word in the same cycle overrides the store.
   assign store_en     = data_we && data_ok && !rst &&
                         !(load_en && (load_addr == data_idx));
   assign load_word    = data_ok ? mem_q[data_idx] : 32'h0;

   // Next-state for the sticky flags and the free-running cycle counter.
   always_comb begin
      halted_d    = halted_q;
      halt_code_d = halt_code_q;
      cycle_d     = halted_q ? cycle_q : cycle_q + 32'd1;
      err_d       = err_q || access_err;
      if (data_we && data_is_halt && !halted_q) begin
         halted_d    = 1'b1;
         halt_code_d = data_wdata;
      end
   end

   // Storage writes. The preload port stays live during reset so that a
   // program can be loaded while the core is held.
   always_ff @(posedge clk) begin
      if (store_en) begin
         mem_q[data_idx] <= data_wdata;
      end
      if (load_en) begin
         mem_q[load_addr] <= load_data;
      end
   end

   // Read pipeline. The word is sampled at the issue edge, which gives
   // read-before-write against a same-cycle store. Each data stage only loads
   // when a valid word arrives, so the last stage holds between returns.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < RD_LATENCY; i++) begin
            vld_q[i]  <= 1'b0;
            rdat_q[i] <= 32'h0;
         end
      end else begin
         vld_q[0] <= data_re;
         if (data_re) begin
            rdat_q[0] <= load_word;
         end
         for (int i = 1; i < RD_LATENCY; i++) begin
            vld_q[i] <= vld_q[i-1];
            if (vld_q[i-1]) begin
               rdat_q[i] <= rdat_q[i-1];
            end
         end
      end
   end

   // Control state: the halt capture, the access-error flag and the cycle counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         halted_q    <= 1'b0;
         halt_code_q <= 32'h0;
         cycle_q     <= 32'h0;
         err_q       <= 1'b0;
      end else begin
         halted_q    <= halted_d;
         halt_code_q <= halt_code_d;
         cycle_q     <= cycle_d;
         err_q       <= err_d;
      end
   end

   assign data_rvalid = vld_q[RD_LATENCY-1];
   assign data_rdata  = rdat_q[RD_LATENCY-1];
   assign halted      = halted_q;
   assign halt_code   = halt_code_q;
   assign cycle_count = cycle_q;
   assign err         = err_q;

endmodule

// File: tb/tb_core_mem_model.sv
// Bench for core_mem_model. It drives one stimulus stream into two instances
// (read latency 1 and 3) and compares them against a word-array reference.
module tb_core_mem_model;

   localparam int          DEPTH     = 64;
   localparam int          AW        = 6;
   localparam logic [31:0] HALT_ADDR = 32'h0000_1000;
   localparam logic [31:0] INIT_WORD = 32'h0000_0013;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic [31:0]   instr_addr, data_addr, data_wdata, load_data;
   logic          data_we, data_re, load_en;
   logic [AW-1:0] load_addr;

   logic [31:0] instr_data_a, data_rdata_a, halt_code_a, cycle_count_a;
   logic        data_rvalid_a, halted_a, err_a;
   logic [31:0] instr_data_b, data_rdata_b, halt_code_b, cycle_count_b;
   logic        data_rvalid_b, halted_b, err_b;

   core_mem_model #(.DEPTH(DEPTH), .RD_LATENCY(1), .HALT_ADDR(HALT_ADDR), .INIT_WORD(INIT_WORD)) u_dut_a (
      .clk(clk), .rst(rst), .instr_addr(instr_addr), .instr_data(instr_data_a),
      .data_addr(data_addr), .data_wdata(data_wdata), .data_we(data_we), .data_re(data_re),
      .data_rdata(data_rdata_a), .data_rvalid(data_rvalid_a), .load_en(load_en),
      .load_addr(load_addr), .load_data(load_data), .halted(halted_a),
      .halt_code(halt_code_a), .cycle_count(cycle_count_a), .err(err_a));

   core_mem_model #(.DEPTH(DEPTH), .RD_LATENCY(3), .HALT_ADDR(HALT_ADDR), .INIT_WORD(INIT_WORD)) u_dut_b (
      .clk(clk), .rst(rst), .instr_addr(instr_addr), .instr_data(instr_data_b),
      .data_addr(data_addr), .data_wdata(data_wdata), .data_we(data_we), .data_re(data_re),
      .data_rdata(data_rdata_b), .data_rvalid(data_rvalid_b), .load_en(load_en),
      .load_addr(load_addr), .load_data(load_data), .halted(halted_b),
      .halt_code(halt_code_b), .cycle_count(cycle_count_b), .err(err_b));

   int checks = 0;
   int errors = 0;

   // Reference model: the memory contents, the flags, and a history of the
   // loads issued at each edge.
   logic [31:0] mem_m [DEPTH];
   bit          halted_m, err_m;
   logic [31:0] code_m, cnt_m;
   bit          hv [8192];
   logic [31:0] hd [8192];
   int          cyc = 0;
   int          rst_edge = 0;
   logic [31:0] lastd [2];
   int          lat [2] = '{1, 3};
   logic [31:0] prog [3] = '{32'h00500093, 32'h00308113, 32'h002081b3};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit in_rng(input logic [31:0] a);
      return (a >> 2) < 32'(DEPTH);
   endfunction

   function automatic logic [31:0] fetch_m(input logic [31:0] a);
      return in_rng(a) ? mem_m[a[AW+1:2]] : INIT_WORD;
   endfunction

   task automatic idle();
      data_we = 1'b0; data_re = 1'b0; load_en = 1'b0;
   endtask

   task automatic st(input logic [31:0] a, input logic [31:0] d);
      data_we = 1'b1; data_re = 1'b0; data_addr = a; data_wdata = d;
   endtask

   task automatic ld(input logic [31:0] a);
      data_we = 1'b0; data_re = 1'b1; data_addr = a;
   endtask

   // Apply the model for one edge using the current inputs, then clock the DUTs and compare.
   task automatic tick();
      int e, src;
      bit ok, hlt, expv;
      logic [AW-1:0] idx;
      cyc++; e = cyc; hv[e] = 1'b0; hd[e] = 32'h0;
      idx = data_addr[AW+1:2];
      ok  = in_rng(data_addr) && (data_addr[1:0] == 2'b00);
      hlt = (data_addr == HALT_ADDR);
      if (rst) begin
         rst_edge = e; halted_m = 1'b0; code_m = 32'h0; cnt_m = 32'h0; err_m = 1'b0;
      end else begin
         if (data_re) begin
            hv[e] = 1'b1;
            hd[e] = ok ? mem_m[idx] : 32'h0;
         end
         if ((data_re || data_we) && !ok && !hlt) err_m = 1'b1;
         if (!halted_m) cnt_m = cnt_m + 32'd1;
         if (data_we) begin
            if (hlt) begin
               if (!halted_m) begin halted_m = 1'b1; code_m = data_wdata; end
            end else if (ok && !(load_en && load_addr == idx)) begin
               mem_m[idx] = data_wdata;
            end
         end
      end
      if (load_en) mem_m[load_addr] = load_data;
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
         src  = e - lat[k] + 1;
         expv = (src >= 1) && (src > rst_edge) && hv[src];
         if (expv) lastd[k] = hd[src];
         if (rst) lastd[k] = 32'h0;
         if (k == 0) begin
            chk("a.rvalid", {31'b0, data_rvalid_a}, {31'b0, expv});
            chk("a.rdata",  data_rdata_a, lastd[k]);
            chk("a.err",    {31'b0, err_a}, {31'b0, err_m});
            chk("a.halted", {31'b0, halted_a}, {31'b0, halted_m});
            chk("a.code",   halt_code_a, code_m);
            chk("a.cycles", cycle_count_a, cnt_m);
            chk("a.fetch",  instr_data_a, fetch_m(instr_addr));
         end else begin
            chk("b.rvalid", {31'b0, data_rvalid_b}, {31'b0, expv});
            chk("b.rdata",  data_rdata_b, lastd[k]);
            chk("b.err",    {31'b0, err_b}, {31'b0, err_m});
            chk("b.halted", {31'b0, halted_b}, {31'b0, halted_m});
            chk("b.code",   halt_code_b, code_m);
            chk("b.cycles", cycle_count_b, cnt_m);
            chk("b.fetch",  instr_data_b, fetch_m(instr_addr));
         end
      end
   endtask

   task automatic rand_phase(input int n, input bit allow_halt);
      for (int i = 0; i < n; i++) begin
         int unsigned r;
         logic [31:0] w;
         w = 32'(3 + $urandom_range(15));
         r = $urandom_range(15);
         data_addr = w << 2;
         if (r == 0) data_addr = (w << 2) | 32'($urandom_range(3, 1));
         else if (r == 1) data_addr = 32'(4 * DEPTH) + (w << 2);
         else if (r == 2 && allow_halt) data_addr = HALT_ADDR;
         data_we    = ($urandom_range(2) == 0);
         data_re    = ($urandom_range(1) == 1);
         load_en    = ($urandom_range(4) == 0);
         load_addr  = AW'(3 + $urandom_range(15));
         load_data  = $urandom;
         data_wdata = $urandom;
         if ($urandom_range(9) == 0) instr_addr = 32'(4 * DEPTH) + 32'(4 * $urandom_range(7));
         else instr_addr = 32'($urandom_range(DEPTH - 1)) << 2;
         tick();
      end
      idle();
   endtask

   initial begin
      rst = 1'b1; instr_addr = 32'h0; data_addr = 32'h0; data_wdata = 32'h0;
      data_we = 1'b0; data_re = 1'b0; load_en = 1'b0; load_addr = '0; load_data = 32'h0;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = INIT_WORD;
      halted_m = 1'b0; err_m = 1'b0; code_m = 32'h0; cnt_m = 32'h0;
      lastd[0] = 32'h0; lastd[1] = 32'h0;

      // Preload the program while reset is held.
      load_en = 1'b1;
      for (int w = 0; w < 3; w++) begin
         load_addr = AW'(w); load_data = prog[w];
         tick();
      end
      idle();
      tick();
      chk("rst.rvalid", {31'b0, data_rvalid_a}, 32'h0);
      chk("rst.rdata",  data_rdata_b, 32'h0);
      chk("rst.err",    {31'b0, err_a}, 32'h0);
      chk("rst.halted", {31'b0, halted_b}, 32'h0);
      chk("rst.cycles", cycle_count_a, 32'h0);

      // Release reset and fetch the program.
      rst = 1'b0;
      for (int w = 0; w < 3; w++) begin
         instr_addr = 32'(w * 4); #1;
         chk("fetch.prog", instr_data_a, prog[w]);
      end
      instr_addr = 32'h10; #1;
      chk("fetch.nop", instr_data_a, INIT_WORD);

      // Store followed by a load: check the latency on both instances.
      st(32'h40, 32'hDEADBEEF); tick();
      ld(32'h40); tick(); idle();
      chk("lat1.v",  {31'b0, data_rvalid_a}, 32'h1);
      chk("lat1.d",  data_rdata_a, 32'hDEADBEEF);
      chk("lat3.v0", {31'b0, data_rvalid_b}, 32'h0);
      tick();
      chk("lat1.off", {31'b0, data_rvalid_a}, 32'h0);
      chk("lat3.v1",  {31'b0, data_rvalid_b}, 32'h0);
      tick();
      chk("lat3.v", {31'b0, data_rvalid_b}, 32'h1);
      chk("lat3.d", data_rdata_b, 32'hDEADBEEF);
      tick();
      chk("lat3.off",  {31'b0, data_rvalid_b}, 32'h0);
      chk("lat3.hold", data_rdata_b, 32'hDEADBEEF);

      // Back-to-back loads return in order.
      ld(32'h0); tick();
      chk("b2b.a0", data_rdata_a, prog[0]);
      ld(32'h4); tick();
      chk("b2b.a1", data_rdata_a, prog[1]);
      ld(32'h8); tick(); idle();
      chk("b2b.a2", data_rdata_a, prog[2]);
      chk("b2b.b0", data_rdata_b, prog[0]);
      tick();
      chk("b2b.ahold", data_rdata_a, prog[2]);
      chk("b2b.b1", data_rdata_b, prog[1]);
      tick();
      chk("b2b.b2", data_rdata_b, prog[2]);
      chk("b2b.bv", {31'b0, data_rvalid_b}, 32'h1);
      tick();

      // A load and a store to the same word in one cycle read the old value.
      st(32'h40, 32'h11); tick();
      data_we = 1'b1; data_wdata = 32'h22; data_re = 1'b1; data_addr = 32'h40;
      tick();
      chk("rbw.old", data_rdata_a, 32'h11);
      ld(32'h40); tick(); idle();
      chk("rbw.new", data_rdata_a, 32'h22);
      tick(); tick();

      // Access errors.
      chk("err.pre", {31'b0, err_a}, 32'h0);
      st(32'h41, 32'h55); tick(); idle();
      chk("err.st_a", {31'b0, err_a}, 32'h1);
      chk("err.st_b", {31'b0, err_b}, 32'h1);
      instr_addr = 32'h40; #1;
      chk("err.memkeep", instr_data_a, 32'h22);
      ld(32'(4 * DEPTH)); tick(); idle();
      chk("err.ld_v", {31'b0, data_rvalid_a}, 32'h1);
      chk("err.ld_d", data_rdata_a, 32'h0);
      tick(); tick();

      // A preload and a store to the same word: the preload wins.
      load_en = 1'b1; load_addr = AW'(5); load_data = 32'h0000AAAA;
      st(32'h14, 32'h0000BBBB); tick(); idle();
      instr_addr = 32'h14; #1;
      chk("preload.wins", instr_data_a, 32'h0000AAAA);

      rand_phase(400, 1'b0);

      // Assert reset with loads in flight.
      ld(32'h4); tick();
      ld(32'h8); tick(); idle();
      rst = 1'b1; #1;
      chk("flush.a_v",  {31'b0, data_rvalid_a}, 32'h0);
      chk("flush.b_v",  {31'b0, data_rvalid_b}, 32'h0);
      chk("flush.b_d",  data_rdata_b, 32'h0);
      chk("flush.err",  {31'b0, err_a}, 32'h0);
      chk("flush.cyc",  cycle_count_b, 32'h0);
      tick(); tick(); tick();
      for (int w = 0; w < 3; w++) begin
         instr_addr = 32'(w * 4); #1;
         chk("flush.prog", instr_data_b, prog[w]);
      end

      // Halt at a known cycle after reset release.
      rst = 1'b0;
      repeat (25) tick();
      st(HALT_ADDR, 32'h1); tick(); idle();
      chk("halt.flag", {31'b0, halted_a}, 32'h1);
      chk("halt.code", halt_code_b, 32'h1);
      chk("halt.cyc",  cycle_count_a, 32'd26);
      repeat (3) tick();
      chk("halt.frozen", cycle_count_b, 32'd26);
      st(HALT_ADDR, 32'h2); tick(); idle();
      chk("halt.second", halt_code_a, 32'h1);

      rand_phase(300, 1'b1);
      tick(); tick(); tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/core_mem_model.md
Name: core_mem_model

Overview:
Parametrised simulation memory model that sits between riscv_core and the bench, replacing hand-driven instr_data/data_rdata stimulus. It provides:
- a combinational instruction fetch port;
- a data port with configurable read latency;
- a preload port for loading programs while the core is held in reset;
- halt detection on a mailbox address, plus a cycle counter, for self-checking benches.

Parameters:
DEPTH, 1024, number of 32-bit words; power of two, minimum 16.
RD_LATENCY, 1, data-port read latency in cycles; legal range 1..4.
HALT_ADDR, 32'h0000_1000, byte address of the halt mailbox; must lie outside 0..4*DEPTH-1.
INIT_WORD, 32'h0000_0013, power-up fill value for every word, and the value returned for out-of-range fetches (NOP).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
instr_addr  in  32  fetch byte address.
instr_data  out  32  fetched word, combinational.
data_addr  in  32  load/store byte address.
data_wdata  in  32  store data.
data_we  in  1  store strobe, one word per cycle.
data_re  in  1  load strobe.
data_rdata  out  32  load data, valid when data_rvalid=1.
data_rvalid  out  1  load-return pulse.
load_en  in  1  preload write strobe.
load_addr  in  clog2(DEPTH)  preload word index.
load_data  in  32  preload data.
halted  out  1  sticky; set by a store to HALT_ADDR.
halt_code  out  32  store data captured at halt.
cycle_count  out  32  cycles since reset release, frozen at halt.
err  out  1  sticky access-error flag.

Behaviour:
- Word index is addr[clog2(DEPTH)+1:2]. An address is in range when addr[31:2] < DEPTH.
- Storage is initialised to INIT_WORD at time zero. rst does NOT clear storage, so a preloaded program survives reset.
- Fetch: instr_data = mem[index(instr_addr)] combinationally. It is valid during rst. An out-of-range fetch returns INIT_WORD and does not set err.
- Store (data_we=1, in range, aligned): mem written at the rising edge. The value is readable by fetch or load from the next cycle.
- Store to HALT_ADDR:
  - storage is untouched;
  - halted<=1 and halt_code<=data_wdata at that edge;
  - only the first halt store is captured; later halt stores are ignored.
- Load (data_re=1):
  - mem is sampled at the issue edge;
  - data_rdata/data_rvalid appear exactly RD_LATENCY cycles after the issue edge;
  - one load may issue every cycle, fully pipelined, and returns stay in order;
  - data_rdata holds its last value when data_rvalid=0.
- data_we and data_re in the same cycle to the same word: read-before-write, so the load returns the old value.
- Misaligned (addr[1:0]!=0) or out-of-range load/store (excluding HALT_ADDR):
  - store is dropped;
  - load still returns, with data 0, after RD_LATENCY;
  - err<=1.
- Preload: load_en=1 writes mem[load_addr]<=load_data at the edge. It works during rst.
- load_en and data_we to the same word in the same cycle: preload wins, and the store is dropped silently.
- cycle_count:
  - 0 during rst;
  - increments by 1 each clk while rst=0 and halted=0;
  - the edge that sets halted still increments;
  - wraps at 2^32 without flagging.
- Reset values: data_rvalid=0, data_rdata=0, halted=0, halt_code=0, cycle_count=0, err=0.
- Asserting rst mid-operation:
  - the read pipeline is flushed immediately;
  - in-flight loads never return;
  - all flags clear.
- No back-pressure: the consumer must accept data_rvalid on the cycle it is asserted.

Test Plan:
- Fetch sequence: preload words 0..2 with 00500093, 00308113, 002081b3 while rst=1, then release. Required: instr_addr 0/4/8 return those words; instr_addr 0x10 returns 00000013.
- Store/load latency: store 0xDEADBEEF to 0x40, then load 0x40 the next cycle. Required, checked for each of RD_LATENCY=1 and 3: data_rvalid pulses exactly that many cycles after issue with 0xDEADBEEF.
- Back-to-back loads: load 0x0, 0x4 and 0x8 on consecutive cycles. Required: three consecutive data_rvalid pulses returning 00500093, 00308113, 002081b3 in order.
- Same-cycle load and store to word 0x40 (old value 0x11, new value 0x22). Required: the load returns 0x11, and a following load returns 0x22.
- Error cases: store to 0x41 -> err=1 and mem unchanged. Load from 4*DEPTH -> data_rdata=0 and err=1.
- Halt and reset:
  - store 0x1 to HALT_ADDR at cycle 25 after release -> halted=1, halt_code=1, cycle_count frozen at 26;
  - a second halt store of 0x2 leaves halt_code=1;
  - asserting rst with a load in flight -> no data_rvalid, all flags 0, preloaded words intact.
